// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl                                                |
// | Purpose  : Stall/flush/forwarding control and MDU hold FSM for a 6-stage   |
// |            F/D/E/M1/M2/W core. Optional macro HAZ_PERF_EN adds counters.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m1,
    input  logic [REG_AW-1:0] rd_m2,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m1,
    input  logic              regwrite_m2,
    input  logic              regwrite_w,
    input  logic              load_e,
    input  logic              load_m1,
    input  logic              pc_src_e,
    input  logic              mdu_start_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m1,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mdu_busy,
`ifdef HAZ_PERF_EN
    output logic [31:0]       perf_lu_cnt,
    output logic [31:0]       perf_mdu_cnt,
`endif
    output logic              mdu_done
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_BUSY   = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;
    localparam logic [3:0] c_CNT_INIT = 4'(MDU_LAT - 2);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_mdu_stall;
    logic       w_lu;

    // Address 0 is hardwired zero and never creates a dependency.
    function automatic logic f_hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return (|rd) && (rd == rs);
    endfunction

    function automatic logic [1:0] f_fwd(input logic [REG_AW-1:0] rs);
        if (regwrite_m1 && !load_m1 && f_hit(rd_m1, rs))
            return 2'b11;
        else if (regwrite_m2 && f_hit(rd_m2, rs))
            return 2'b10;
        else if (regwrite_w && f_hit(rd_w, rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (mdu_start_e) begin
                    w_state_nxt = c_S_BUSY;
                    w_cnt_nxt   = c_CNT_INIT;
                end
            end
            c_S_BUSY: begin
                if (r_cnt == 4'd0)
                    w_state_nxt = c_S_DONE;
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            // The start flag is still high for the finishing op; ignore it here.
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_mdu_stall = ((r_state == c_S_IDLE) && mdu_start_e) || (r_state == c_S_BUSY);
        w_lu = (load_e  && regwrite_e  && (f_hit(rd_e,  rs1_d) || f_hit(rd_e,  rs2_d))) ||
               (load_m1 && regwrite_m1 && (f_hit(rd_m1, rs1_d) || f_hit(rd_m1, rs2_d)));
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m1 = 1'b0;
        // E is held during an MDU stall, so neither a branch nor a load-use bubble applies.
        if (w_mdu_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m1 = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
        fwd_a_e  = f_fwd(rs1_e);
        fwd_b_e  = f_fwd(rs2_e);
        mdu_busy = (r_state != c_S_IDLE);
        mdu_done = (r_state == c_S_DONE);
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lu_cnt  <= 32'd0;
            perf_mdu_cnt <= 32'd0;
        end else begin
            if (w_lu && !w_mdu_stall && !pc_src_e)
                perf_lu_cnt <= perf_lu_cnt + 32'd1;
            if (w_mdu_stall)
                perf_mdu_cnt <= perf_mdu_cnt + 32'd1;
        end
    end
`endif

    a_no_branch_in_mdu_stall: assert property (@(posedge clk) disable iff (reset)
        !(w_mdu_stall && pc_src_e));

endmodule
`default_nettype wire
